// File: rtl/multicycle_control_unit_pkg.sv
// Shared control types for the RV64 control units: ALU/writeback selects,
// multi-cycle state encoding, instruction classes and opcode/funct constants.
package multicycle_control_unit_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } aluOperation_t;

  typedef enum logic {
    ALU_SRC_REG = 1'b0,
    ALU_SRC_IMM = 1'b1
  } aluDataSrc_t;

  typedef enum logic {
    REG_SRC_ALU = 1'b0,
    REG_SRC_MEM = 1'b1
  } regDataSrc_t;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    FAULT     = 3'd5
  } ctrlState_t;

  typedef enum logic [3:0] {
    CLS_NONE = 4'd0,
    CLS_LD   = 4'd1,
    CLS_SD   = 4'd2,
    CLS_ADD  = 4'd3,
    CLS_SUB  = 4'd4,
    CLS_AND  = 4'd5,
    CLS_OR   = 4'd6,
    CLS_BEQ  = 4'd7,
    CLS_ADDI = 4'd8,
    CLS_ANDI = 4'd9,
    CLS_ORI  = 4'd10
  } instrClass_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [2:0] F3_AND   = 3'b111;
  localparam logic [2:0] F3_OR    = 3'b110;
  localparam logic [2:0] F3_DWORD = 3'b011;
  localparam logic [2:0] F3_BEQ   = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  function automatic aluOperation_t class_alu_op(input instrClass_t cls);
    aluOperation_t op;
    case (cls)
      CLS_SUB, CLS_BEQ:  op = OP_SUB;
      CLS_AND, CLS_ANDI: op = OP_AND;
      CLS_OR, CLS_ORI:   op = OP_OR;
      default:           op = OP_ADD;
    endcase
    return op;
  endfunction

  function automatic aluDataSrc_t class_alu_src(input instrClass_t cls);
    aluDataSrc_t src;
    case (cls)
      CLS_LD, CLS_SD, CLS_ADDI, CLS_ANDI, CLS_ORI: src = ALU_SRC_IMM;
      default:                                     src = ALU_SRC_REG;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_instr_classifier.sv
// Combinational instruction classifier: opcode/funct3/funct7 to instruction
// class, with anything outside the supported subset flagged illegal.
module instr_classifier
  import multicycle_control_unit_pkg::*;
#(
  parameter int ENABLE_IMM_OPS = 1
) (
  input  logic [6:0]  opcode_in,
  input  logic [2:0]  funct3_in,
  input  logic [6:0]  funct7_in,
  output instrClass_t class_out,
  output logic        illegal_out
);

  always_comb begin
    class_out = CLS_NONE;
    case (opcode_in)
      OPC_LOAD:   if (funct3_in == F3_DWORD) class_out = CLS_LD;
      OPC_STORE:  if (funct3_in == F3_DWORD) class_out = CLS_SD;
      OPC_BRANCH: if (funct3_in == F3_BEQ)   class_out = CLS_BEQ;
      OPC_OP: begin
        if (funct7_in == F7_BASE) begin
          case (funct3_in)
            F3_ADD:  class_out = CLS_ADD;
            F3_AND:  class_out = CLS_AND;
            F3_OR:   class_out = CLS_OR;
            default: class_out = CLS_NONE;
          endcase
        end else if (funct7_in == F7_ALT && funct3_in == F3_ADD) begin
          class_out = CLS_SUB;
        end
      end
      OPC_OP_IMM: begin
        if (ENABLE_IMM_OPS != 0) begin
          case (funct3_in)
            F3_ADD:  class_out = CLS_ADDI;
            F3_AND:  class_out = CLS_ANDI;
            F3_OR:   class_out = CLS_ORI;
            default: class_out = CLS_NONE;
          endcase
        end
      end
      default: class_out = CLS_NONE;
    endcase
  end

  assign illegal_out = (class_out == CLS_NONE);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV64 control unit: sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// with memory handshakes, wait timeout, sticky fault and retire counter.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int ENABLE_IMM_OPS = 1,
  parameter int MEM_TIMEOUT    = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [31:0]          instr_in,
  input  logic                 instrValid_in,
  input  logic                 memReady_in,
  input  logic                 aluZero_in,
  output logic                 instrReq_out,
  output logic                 irWrite_out,
  output logic                 pcWrite_out,
  output logic                 pcSrcCtrl_out,
  output aluDataSrc_t          aluSrcCtrl_out,
  output aluOperation_t        aluOp_out,
  output logic                 memRead_out,
  output logic                 memWrite_out,
  output logic                 regWrite_out,
  output regDataSrc_t          regSrcCtrl_out,
  output logic                 fault_out,
  output ctrlState_t           state_out,
  output logic [CNT_WIDTH-1:0] retired_out
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrlState_t           r_state;
  ctrlState_t           w_stateNext;
  logic [6:0]           r_opcode;
  logic [2:0]           r_funct3;
  logic [6:0]           r_funct7;
  logic [WAIT_W-1:0]    r_waitCnt;
  logic [CNT_WIDTH-1:0] r_retired;
  logic [CNT_WIDTH-1:0] w_retiredNext;
  instrClass_t          w_class;
  logic                 w_illegal;
  logic                 w_waiting;
  logic                 w_timeout;
  logic                 w_retire;

  instr_classifier #(
    .ENABLE_IMM_OPS(ENABLE_IMM_OPS)
  ) u_classifier (
    .opcode_in  (r_opcode),
    .funct3_in  (r_funct3),
    .funct7_in  (r_funct7),
    .class_out  (w_class),
    .illegal_out(w_illegal)
  );

  assign w_waiting = ((r_state == FETCH) && !instrValid_in) ||
                     ((r_state == MEM) && !memReady_in);
  // A ready arriving on the last allowed cycle clears w_waiting, so it wins.
  assign w_timeout = (MEM_TIMEOUT != 0) && w_waiting && (r_waitCnt == WAIT_LAST);

  assign w_retiredNext = (&r_retired) ? r_retired : r_retired + CNT_WIDTH'(w_retire);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= FETCH;
      r_waitCnt <= '0;
      r_retired <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_retired <= w_retiredNext;
      if (w_stateNext != r_state) begin
        r_waitCnt <= '0;
      end else if (w_waiting) begin
        r_waitCnt <= r_waitCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (r_state == FETCH && instrValid_in) begin
      r_opcode <= instr_in[6:0];
      r_funct3 <= instr_in[14:12];
      r_funct7 <= instr_in[31:25];
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_retire       = 1'b0;
    instrReq_out   = 1'b0;
    irWrite_out    = 1'b0;
    pcWrite_out    = 1'b0;
    pcSrcCtrl_out  = 1'b0;
    aluSrcCtrl_out = ALU_SRC_REG;
    aluOp_out      = OP_ADD;
    memRead_out    = 1'b0;
    memWrite_out   = 1'b0;
    regWrite_out   = 1'b0;
    regSrcCtrl_out = REG_SRC_ALU;
    case (r_state)
      FETCH: begin
        instrReq_out = 1'b1;
        if (instrValid_in) begin
          irWrite_out = 1'b1;
          w_stateNext = DECODE;
        end else if (w_timeout) begin
          w_stateNext = FAULT;
        end
      end
      DECODE: w_stateNext = w_illegal ? FAULT : EXECUTE;
      EXECUTE: begin
        aluOp_out      = class_alu_op(w_class);
        aluSrcCtrl_out = class_alu_src(w_class);
        if (w_class == CLS_BEQ) begin
          pcWrite_out   = 1'b1;
          pcSrcCtrl_out = aluZero_in;
          w_retire      = 1'b1;
          w_stateNext   = FETCH;
        end else if (w_class == CLS_LD || w_class == CLS_SD) begin
          w_stateNext = MEM;
        end else begin
          w_stateNext = WRITEBACK;
        end
      end
      MEM: begin
        aluOp_out      = OP_ADD;
        aluSrcCtrl_out = ALU_SRC_IMM;
        memRead_out    = (w_class == CLS_LD);
        memWrite_out   = (w_class == CLS_SD);
        if (memReady_in) begin
          if (w_class == CLS_LD) begin
            w_stateNext = WRITEBACK;
          end else begin
            pcWrite_out = 1'b1;
            w_retire    = 1'b1;
            w_stateNext = FETCH;
          end
        end else if (w_timeout) begin
          w_stateNext = FAULT;
        end
      end
      WRITEBACK: begin
        aluOp_out      = class_alu_op(w_class);
        aluSrcCtrl_out = class_alu_src(w_class);
        regWrite_out   = 1'b1;
        pcWrite_out    = 1'b1;
        regSrcCtrl_out = (w_class == CLS_LD) ? REG_SRC_MEM : REG_SRC_ALU;
        w_retire       = 1'b1;
        w_stateNext    = FETCH;
      end
      FAULT:   w_stateNext = FAULT;
      default: w_stateNext = FAULT;
    endcase
    // Outputs are held quiet for the whole reset cycle.
    if (rst_in) begin
      instrReq_out   = 1'b0;
      irWrite_out    = 1'b0;
      pcWrite_out    = 1'b0;
      pcSrcCtrl_out  = 1'b0;
      aluSrcCtrl_out = ALU_SRC_REG;
      aluOp_out      = OP_ADD;
      memRead_out    = 1'b0;
      memWrite_out   = 1'b0;
      regWrite_out   = 1'b0;
      regSrcCtrl_out = REG_SRC_ALU;
    end
  end

  assign fault_out   = !rst_in && (r_state == FAULT);
  assign state_out   = r_state;
  assign retired_out = rst_in ? '0 : w_retiredNext;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle control decoder for the RV64 datapath.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK with ready/valid waits on instruction and data memory.
- Adds optional I-type ALU ops, branch resolution from the ALU zero flag, memory timeout fault, and a retired-instruction counter.
- Sits between the instruction/data memory interfaces and the shared datapath: PC, IR, register file, ALU.

Parameters:
- ENABLE_IMM_OPS, 1: when 1, opcode 0010011 funct3 000/111/110 (addi/andi/ori) is legal; when 0 it is illegal.
- MEM_TIMEOUT, 16: maximum wait cycles in FETCH or MEM before faulting; 0 disables the timeout.
- CNT_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clk_in  in  1  clock; all state changes on its rising edge.
- rst_in  in  1  synchronous, active-high reset.
- instr_in  in  32  instruction word; valid when instrValid_in=1.
- instrValid_in  in  1  instruction memory data ready.
- memReady_in  in  1  data memory access complete.
- aluZero_in  in  1  ALU zero flag.
- instrReq_out  out  1  instruction fetch request.
- irWrite_out  out  1  load IR from instr_in.
- pcWrite_out  out  1  update PC this cycle.
- pcSrcCtrl_out  out  1  0 = PC+4, 1 = branch target.
- aluSrcCtrl_out  out  aluDataSrc_t  ALU operand B select.
- aluOp_out  out  aluOperation_t  ALU operation.
- memRead_out  out  1  data memory read.
- memWrite_out  out  1  data memory write.
- regWrite_out  out  1  register file write enable.
- regSrcCtrl_out  out  regDataSrc_t  writeback source.
- fault_out  out  1  sticky fault flag (illegal instruction or timeout).
- state_out  out  ctrlState_t  current state, for debug.
- retired_out  out  CNT_WIDTH  retired-instruction count.

Behaviour:
- Reset (rst_in=1 at a clock edge): state=FETCH, all 1-bit outputs 0, aluOp_out=OP_ADD, aluSrcCtrl_out=ALU_SRC_REG, regSrcCtrl_out=REG_SRC_ALU, retired_out=0, wait counter=0, fault cleared. Reset overrides every other event in the same cycle.
- Outputs are Moore, decoded from the state plus the latched decode fields. The only exceptions are irWrite_out and the FETCH exit, which qualify on instrValid_in.
- FETCH:
  - instrReq_out=1.
  - If instrValid_in=1: irWrite_out=1 in that cycle, latch opcode/funct3/funct7 from instr_in, go to DECODE.
  - Otherwise increment the wait counter.
- DECODE (one cycle):
  - Classify the instruction: ld 0000011, sd 0100011, R-type 0110011 (add/sub/and/or), beq 1100011 funct3 000, I-ALU.
  - Anything else, including unlisted funct3/funct7 combinations, goes to FAULT.
- EXECUTE (one cycle): aluOp_out/aluSrcCtrl_out per class.
  - ld/sd/addi: ADD, IMM. sub/beq: SUB, REG. and/or/andi/ori: AND/OR, REG or IMM.
  - R/I ALU ops go to WRITEBACK; ld/sd go to MEM.
  - beq: pcWrite_out=1, pcSrcCtrl_out=aluZero_in, retire, go to FETCH.
- MEM:
  - memRead_out (ld) or memWrite_out (sd) held until memReady_in=1; aluOp_out=OP_ADD, aluSrcCtrl_out=ALU_SRC_IMM.
  - On ready, ld goes to WRITEBACK (regSrcCtrl_out=REG_SRC_MEM).
  - On ready, sd asserts pcWrite_out=1 (PC+4), retires, and goes to FETCH.
- WRITEBACK (one cycle): regWrite_out=1, pcWrite_out=1, pcSrcCtrl_out=0, retire, go to FETCH.
- Latency with zero-wait memories: beq 3 cycles, R/I-ALU 4, sd 4, ld 5.
- Wait counter: reset on every state change. When it reaches MEM_TIMEOUT while still waiting (MEM_TIMEOUT≠0), go to FAULT. A ready arriving on that same cycle wins: no fault.
- FAULT: fault_out=1, all enables 0, and it stays there until reset. No retire.
- retired_out increments by 1 on each retiring cycle and saturates at all-ones (no wrap).
- sd and beq must never assert regWrite_out. memRead_out and memWrite_out are never asserted together.

Decomposition:
- Shared control package: reuse aluOperation_t, aluDataSrc_t, regDataSrc_t. Add ctrlState_t (FETCH, DECODE, EXECUTE, MEM, WRITEBACK, FAULT), an instrClass_t enum, and opcode/funct constants.
- Sub-module instr_classifier: combinational map from opcode/funct3/funct7 and ENABLE_IMM_OPS to instrClass_t plus an illegal flag. Reusable by the single-cycle decoder.

Test Plan:
- Reset, then add (0x002081B3) with instrValid_in=1 immediately:
  - Required: states FETCH→DECODE→EXECUTE→WRITEBACK.
  - WRITEBACK cycle has regWrite_out=1, aluOp OP_ADD, retired_out=1.
- ld (0x0000B183) with memReady_in delayed 3 cycles:
  - Required: memRead_out high 4 cycles, then WRITEBACK with REG_SRC_MEM, 8 cycles total.
- beq (0x00208063) with aluZero_in=1, then again with 0:
  - Required: pcSrcCtrl_out 1 then 0, with pcWrite_out=1 in EXECUTE.
  - regWrite_out, memRead_out and memWrite_out stay 0 throughout.
- addi (0x00508093):
  - With ENABLE_IMM_OPS=1: OP_ADD/ALU_SRC_IMM, then regWrite.
  - With ENABLE_IMM_OPS=0: FAULT, fault_out=1, retired_out unchanged.
- MEM_TIMEOUT=4, sd (0x0020B023) with memReady_in held 0:
  - Required: FAULT after 4 wait cycles.
  - A repeat run with ready asserted on the 4th cycle completes normally.
- CNT_WIDTH=2, retire 5 instructions → retired_out=3 (saturated). Assert rst_in mid-MEM → next cycle FETCH, all enables 0.
